adder: RTL and testbench
========================

ADDER -- requirements
Module: adder

Interface
REQ-001 Parameter WIDTH, default 4: operand and result width in bits; legal range 1..64.
REQ-002 Port clk  input  1  single rising-edge clock for all state.
REQ-003 Port rst  input  1  reset, synchronous and active-high.
REQ-004 Port in_valid  input  1  a/b are valid this cycle.
REQ-005 Port a  input  WIDTH  unsigned operand A.
REQ-006 Port b  input  WIDTH  unsigned operand B.
REQ-007 Port result  output  WIDTH  registered sum (a+b), low WIDTH bits, or saturated value (see Configuration).
REQ-008 Port carry_out  output  1  registered unsigned carry, bit WIDTH of the full sum.
REQ-009 Port overflow  output  1  registered two's-complement overflow flag: operand MSBs equal, sum MSB different.
REQ-010 Port zero  output  1  registered flag: result == 0.
REQ-011 Port odd  output  1  registered flag: result[0].
REQ-012 Port out_valid  output  1  result and flags are valid this cycle.

Function
REQ-013 The adder SHALL compute the full sum {carry, sum} = a + b at WIDTH+1 bits, with no sign extension of the operands.
REQ-014 Latency SHALL be exactly 1 cycle: operands sampled at edge N with in_valid=1 appear on result/flags with out_valid=1 after edge N.
REQ-015 out_valid SHALL equal in_valid delayed by one cycle; no backpressure, a new operand pair is accepted every cycle.
REQ-016 When in_valid=0, result, carry_out, overflow, zero and odd SHALL hold their previous values; only out_valid drops.
REQ-017 Without saturation, result SHALL wrap modulo 2^WIDTH (e.g. WIDTH=4: 15+15 gives result=14, carry_out=1).
REQ-018 zero and odd SHALL be derived from the final registered result, including after saturation.
REQ-019 overflow SHALL be computed from the unsaturated sum, independent of the Configuration feature.
REQ-020 Parity SHALL follow the arithmetic: even+even gives even, odd+odd gives even, and mixed parity gives odd, unless saturated.
REQ-021 The design SHALL be purely synchronous, with no latches and no combinational path from inputs to outputs.

Reset
REQ-022 While rst=1 at a rising clk edge, result=0, carry_out=0, overflow=0, odd=0, out_valid=0 and zero=1.
REQ-023 rst SHALL take priority over in_valid; an operand pair presented in the same cycle as rst is discarded.
REQ-024 The first valid output after rst is released SHALL appear one cycle after the first in_valid=1 sample.

Configuration
REQ-025 Macro ADDER_SATURATE_EN SHALL select saturating behaviour.
- Defined: if the full sum exceeds 2^WIDTH-1, result SHALL be all ones; carry_out still reports the raw carry.
- Undefined: result SHALL wrap as in REQ-017, with no saturation logic synthesized.

Verification
REQ-026 Bench at WIDTH=4 SHALL cover these directed scenarios:
- rst=1 for 2 cycles, then a=0, b=0, in_valid=1 -> next cycle result=0, zero=1, odd=0, carry_out=0, out_valid=1.
- a=7, b=7 (largest values with MSB cleared) -> result=14, carry_out=0, overflow=1, odd=0.
- a=15, b=15 -> result=14, carry_out=1, overflow=0; with ADDER_SATURATE_EN defined, result=15 and odd=1.
- 10 random pairs, a odd and b even, MSBs cleared -> result=a+b, odd=1, carry_out=0; repeat with even+even and odd+odd -> odd=0.
- a=3, b=5 then in_valid=0 for 3 cycles -> result stays 8 and out_valid=0 after the first output cycle.
- Back-to-back pairs (1,2), (4,4) with rst asserted in the second cycle -> no output for (4,4), outputs at reset values, out_valid=0.

Source files
------------

// File: rtl/adder.sv
// -----------------------------------------------------------------------------
// adder: registered unsigned WIDTH-bit adder with carry, signed-overflow,
// zero and odd flags, and a one-cycle valid pipeline.
//
// Optional feature macro: ADDER_SATURATE_EN
//   defined   -> result clamps to all ones when the full sum exceeds 2^WIDTH-1
//   undefined -> result wraps modulo 2^WIDTH (no saturation logic built)
// carry_out and overflow always describe the raw, unsaturated sum; zero and
// odd always describe the final registered result.
// -----------------------------------------------------------------------------
module adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             odd,
  output logic             out_valid
);

  localparam logic [WIDTH-1:0] ALL_ZEROS = {WIDTH{1'b0}};
`ifdef ADDER_SATURATE_EN
  localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};
`endif

  // Zero-extend both operands so bit WIDTH of the sum is the unsigned carry.
  function automatic logic [WIDTH:0] full_sum(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

  // Two's-complement overflow: operands agree in sign, sum disagrees.
  function automatic logic twos_overflow(input logic x_msb,
                                         input logic y_msb,
                                         input logic s_msb);
    return (x_msb == y_msb) && (s_msb != x_msb);
  endfunction

  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] final_s;
  logic             ovf_s;

  logic [WIDTH-1:0] result_d,    result_q;
  logic             carry_d,     carry_q;
  logic             overflow_d,  overflow_q;
  logic             zero_d,      zero_q;
  logic             odd_d,       odd_q;
  logic             out_valid_d, out_valid_q;

  // Arithmetic datapath: raw sum, overflow and the (optionally clamped) result.
  always_comb begin
    sum_s   = full_sum(a, b);
    ovf_s   = twos_overflow(a[WIDTH-1], b[WIDTH-1], sum_s[WIDTH-1]);
    final_s = sum_s[WIDTH-1:0];
`ifdef ADDER_SATURATE_EN
    if (sum_s[WIDTH]) begin
      final_s = ALL_ONES;
    end else begin
      final_s = sum_s[WIDTH-1:0];
    end
`endif
  end

  // Next-state: load a new result on in_valid, otherwise hold everything
  // except out_valid, which simply follows in_valid.
  always_comb begin
    result_d    = result_q;
    carry_d     = carry_q;
    overflow_d  = overflow_q;
    zero_d      = zero_q;
    odd_d       = odd_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      result_d   = final_s;
      carry_d    = sum_s[WIDTH];
      overflow_d = ovf_s;
      zero_d     = (final_s == ALL_ZEROS);
      odd_d      = final_s[0];
    end else begin
      result_d   = result_q;
      carry_d    = carry_q;
      overflow_d = overflow_q;
      zero_d     = zero_q;
      odd_d      = odd_q;
    end
  end

  // Output registers; synchronous reset wins over any operand in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q    <= ALL_ZEROS;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b1;
      odd_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      carry_q     <= carry_d;
      overflow_q  <= overflow_d;
      zero_q      <= zero_d;
      odd_q       <= odd_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign result    = result_q;
  assign carry_out = carry_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;
  assign odd       = odd_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_adder.sv
// -----------------------------------------------------------------------------
// tb_adder: self-checking bench for adder at WIDTH=4. Directed scenarios use
// hand-derived constants; random traffic is checked against an integer model.
// Observed vector layout: {out_valid, result[3:0], carry_out, overflow, zero, odd}
// -----------------------------------------------------------------------------
module tb_adder;

  localparam int W = 4;
  localparam logic [8:0] RESET_VEC = 9'b0_0000_0010;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;
  logic         zero;
  logic         odd;
  logic         out_valid;

  int n_vec;
  int n_bad;

  adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero),
    .odd       (odd),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model from plain integer arithmetic: returns {result,carry,ovf,zero,odd}.
  function automatic logic [7:0] model(input int unsigned x, input int unsigned y);
    int unsigned s;
    int unsigned r;
    int          sx;
    int          sy;
    int          ss;
    logic        c;
    logic        v;
    s = x + y;
    c = (s > 15);
`ifdef ADDER_SATURATE_EN
    r = (s > 15) ? 15 : s;
`else
    r = s % 16;
`endif
    sx = (x >= 8) ? int'(x) - 16 : int'(x);
    sy = (y >= 8) ? int'(y) - 16 : int'(y);
    ss = sx + sy;
    v  = (ss > 7) || (ss < -8);
    return {r[3:0], c, v, (r == 0), (r % 2 == 1)};
  endfunction

  function automatic logic [8:0] observed();
    return {out_valid, result, carry_out, overflow, zero, odd};
  endfunction

  task automatic step(input logic [W-1:0] xa, input logic [W-1:0] xb,
                      input logic v, input logic r);
    a        = xa;
    b        = xb;
    in_valid = v;
    rst      = r;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(4'd9, 4'd9, 1'b1, 1'b1);
      n_vec++;
      if (observed() !== RESET_VEC) begin
        n_bad++;
        $display("FAIL reset_cycle%0d: got %b expected %b", i, observed(), RESET_VEC);
      end
    end
    step(4'd0, 4'd0, 1'b1, 1'b0);
    n_vec++;
    if (observed() !== 9'b1_0000_0010) begin
      n_bad++;
      $display("FAIL first_after_reset: got %b expected %b", observed(), 9'b1_0000_0010);
    end
  endtask

  task automatic test_msb_clear_max();
    step(4'd7, 4'd7, 1'b1, 1'b0);
    n_vec++;
    if (observed() !== 9'b1_1110_0100) begin
      n_bad++;
      $display("FAIL add_7_7: got %b expected %b", observed(), 9'b1_1110_0100);
    end
  endtask

  task automatic test_all_ones();
    logic [8:0] exp;
`ifdef ADDER_SATURATE_EN
    exp = 9'b1_1111_1001;
`else
    exp = 9'b1_1110_1000;
`endif
    step(4'd15, 4'd15, 1'b1, 1'b0);
    n_vec++;
    if (observed() !== exp) begin
      n_bad++;
      $display("FAIL add_15_15: got %b expected %b", observed(), exp);
    end
  endtask

  task automatic test_parity();
    logic [W-1:0] xa;
    logic [W-1:0] xb;
    logic [7:0]   m;
    for (int kind = 0; kind < 3; kind++) begin
      for (int i = 0; i < 10; i++) begin
        xa = 4'($urandom_range(0, 3) * 2 + ((kind != 1) ? 1 : 0));
        xb = 4'($urandom_range(0, 3) * 2 + ((kind == 2) ? 1 : 0));
        step(xa, xb, 1'b1, 1'b0);
        m = model(int'(xa), int'(xb));
        n_vec++;
        if (observed() !== {1'b1, m} || result !== xa + xb || odd !== (kind == 0)
            || carry_out !== 1'b0) begin
          n_bad++;
          $display("FAIL parity_k%0d a=%0d b=%0d: got %b expected %b", kind, xa, xb,
                   observed(), {1'b1, m});
        end
      end
    end
  endtask

  task automatic test_hold();
    step(4'd3, 4'd5, 1'b1, 1'b0);
    n_vec++;
    if (observed() !== 9'b1_1000_0100) begin
      n_bad++;
      $display("FAIL hold_load: got %b expected %b", observed(), 9'b1_1000_0100);
    end
    for (int i = 0; i < 3; i++) begin
      step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0, 1'b0);
      n_vec++;
      if (observed() !== 9'b0_1000_0100) begin
        n_bad++;
        $display("FAIL hold_idle%0d: got %b expected %b", i, observed(), 9'b0_1000_0100);
      end
    end
  endtask

  task automatic test_back_to_back();
    step(4'd1, 4'd2, 1'b1, 1'b0);
    n_vec++;
    if (observed() !== 9'b1_0011_0001) begin
      n_bad++;
      $display("FAIL b2b_first: got %b expected %b", observed(), 9'b1_0011_0001);
    end
    step(4'd4, 4'd4, 1'b1, 1'b1);
    n_vec++;
    if (observed() !== RESET_VEC) begin
      n_bad++;
      $display("FAIL b2b_reset: got %b expected %b", observed(), RESET_VEC);
    end
    step(4'd0, 4'd0, 1'b0, 1'b0);
    n_vec++;
    if (observed() !== RESET_VEC) begin
      n_bad++;
      $display("FAIL b2b_after_reset: got %b expected %b", observed(), RESET_VEC);
    end
  endtask

  task automatic test_random_stream();
    logic [7:0]   held;
    logic [W-1:0] xa;
    logic [W-1:0] xb;
    logic         v;
    held = RESET_VEC[7:0];
    for (int i = 0; i < 60; i++) begin
      xa = 4'($urandom_range(0, 15));
      xb = 4'($urandom_range(0, 15));
      v  = 1'($urandom_range(0, 3) != 0);
      step(xa, xb, v, 1'b0);
      if (v) held = model(int'(xa), int'(xb));
      n_vec++;
      if (observed() !== {v, held}) begin
        n_bad++;
        $display("FAIL stream%0d a=%0d b=%0d v=%0b: got %b expected %b", i, xa, xb, v,
                 observed(), {v, held});
      end
    end
  endtask

  initial begin
    n_vec    = 0;
    n_bad    = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    a        = 4'd0;
    b        = 4'd0;
    test_reset();
    test_msb_clear_max();
    test_all_ones();
    test_parity();
    test_hold();
    test_back_to_back();
    test_random_stream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
